pwm_carrier_gen: RTL and testbench
==================================

Name: pwm_carrier_gen

Overview:
Parametrised carrier generator for the motor PWM path, and the successor to the fixed 8-bit triangle source. It produces a programmable-width carrier in up-sawtooth, down-sawtooth or triangle mode, with a programmable period and a clock prescaler. It drives CHANNELS compare-based PWM outputs. Period, mode and compare values are double-buffered: they change only at the period boundary, so PWM outputs never glitch.

Parameters:
WIDTH, 8, carrier, period and compare width in bits (2..16)
CHANNELS, 2, number of PWM compare channels (1..8)
PSC_WIDTH, 8, prescaler divide-register width

Ports:
cclk  input  1  system clock, all logic on rising edge
rstb  input  1  asynchronous active-low reset
enable  input  1  1 = carrier runs; 0 = carrier holds, prescaler cleared
mode_in  input  2  shadow mode: 0 up-saw, 1 down-saw, 2 triangle, 3 reserved (treated as 0)
top_in  input  WIDTH  shadow period top value
psc_in  input  PSC_WIDTH  prescaler: carrier advances once per psc_in+1 clocks
cmp_in  input  CHANNELS*WIDTH  shadow compare values; channel i is bits [i*WIDTH +: WIDTH]
carrier  output  WIDTH  registered carrier count
dir  output  1  1 = counting up, 0 = counting down
evt_zero  output  1  one-clock pulse in the cycle carrier becomes 0 on a tick
evt_top  output  1  one-clock pulse in the cycle carrier becomes active top on a tick
pwm_out  output  CHANNELS  pwm_out[i] = registered (carrier < cmp_active[i])

Behaviour:
- Reset (async, rstb=0):
  - carrier=0, dir=1, evt_zero=0, evt_top=0, pwm_out=0, prescaler count=0.
  - Active registers: top_act=all-ones, mode_act=0, cmp_act=0.
  - Reset mid-period takes effect immediately; after rstb rises, the first tick proceeds from 0.
- Prescaler:
  - psc_cnt counts 0..psc_in; tick=1 when enable and psc_cnt==psc_in, then psc_cnt returns to 0.
  - psc_in=0 gives a tick every clock. psc_in is used live (not shadowed).
  - enable=0: psc_cnt held at 0, no ticks, carrier/dir held, evt_* = 0.
  - While enable=0, active registers load from the shadow inputs every clock.
- Carrier advance on tick:
  - up-saw: carrier==top_act → 0 (update point), else +1. dir=1.
  - down-saw: carrier==0 → top (update point), else −1. dir=0.
  - triangle:
    - Counting up: +1 until carrier==top_act, then dir←0 and count down.
    - Counting down: −1 until 0, then dir←1.
    - Sequence is 0,1..top..1,0; period is 2*top ticks.
    - The transition into 0 is the update point.
- Update point:
  - mode_act, top_act and cmp_act load from mode_in, top_in and cmp_in in the same clock.
  - The carrier loads the start value of the NEW mode: 0 for up-saw or triangle (dir=1), the new top for down-saw (dir=0).
- Shadow inputs changed mid-period have no effect until the next update point.
- Events:
  - evt_zero and evt_top are registered with carrier and assert on the tick where carrier takes that value.
  - Both assert together when top_act=0.
  - When top_act=0 the carrier stays at 0; every tick is an update point and asserts evt_zero and evt_top.
- PWM:
  - pwm_out[i] registered from the current carrier and cmp_act[i], so it lags carrier by one clock.
  - cmp=0 gives constant 0. cmp>top gives constant 1.
  - Outputs remain computed while enable=0.
- No arithmetic overflow: top_in=2^WIDTH−1 is legal. Wrap is by compare, never by natural overflow.

Test Plan:
1. Reset: assert rstb=0 mid-count with carrier=5 → immediately carrier=0, dir=1, pwm_out=0, evt_*=0. Release; with enable=0, top/mode/cmp load directly.
2. Up-saw, WIDTH=8, top=4, psc=0, cmp0=2, cmp1=5:
   - carrier 0,1,2,3,4,0…; evt_zero every 5 clocks; evt_top on 4.
   - pwm_out[0] high 2 of 5 clocks (one-clock lag); pwm_out[1] constant 1.
3. Triangle, top=3:
   - carrier 0,1,2,3,2,1,0,1…; dir falls in the clock carrier=3.
   - evt_top once and evt_zero once per 6-clock period.
4. Prescaler psc=2, up-saw top=2 → carrier changes every 3 clocks: 0,0,0,1,1,1,2,2,2,0.
5. Shadow update in up-saw with top 4, cmp0 1:
   - Set top_in=6, cmp_in=3 while carrier=2 → sequence still reaches 4, wraps to 0.
   - Next period counts to 6; pwm_out[0] switches to a 3-of-7 duty from the first clock after the wrap.
6. Mode switch and top=0:
   - mode_in 0→1 mid-period → at the wrap, carrier loads the new top and counts down.
   - top_in=0 → carrier stuck at 0, evt_zero=evt_top=1 every tick.

Source files
------------

// File: rtl/pwm_carrier_gen.sv
// Programmable carrier (up-saw / down-saw / triangle) with prescaler and
// CHANNELS compare outputs; period, mode and compares reload at the update point.
//
// mode      | meaning
// ----------+---------------------------------------------------------------
// MODE_UP   | 0..top, wraps to 0 (update point), dir=1
// MODE_DN   | top..0, reloads top from 0 (update point), dir=0
// MODE_TRI  | 0..top..0, dir flips at top, arrival at 0 is the update point
// 3         | reserved, loaded as MODE_UP
module pwm_carrier_gen #(
   parameter int WIDTH     = 8,
   parameter int CHANNELS  = 2,
   parameter int PSC_WIDTH = 8
) (
   input  logic                         cclk,
   input  logic                         rstb,
   input  logic                         enable,
   input  logic [1:0]                   mode_in,
   input  logic [WIDTH-1:0]             top_in,
   input  logic [PSC_WIDTH-1:0]         psc_in,
   input  logic [CHANNELS*WIDTH-1:0]    cmp_in,
   output logic [WIDTH-1:0]             carrier,
   output logic                         dir,
   output logic                         evt_zero,
   output logic                         evt_top,
   output logic [CHANNELS-1:0]          pwm_out
);

   localparam logic [1:0]       MODE_UP  = 2'd0;
   localparam logic [1:0]       MODE_DN  = 2'd1;
   localparam logic [1:0]       MODE_TRI = 2'd2;
   localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);

   logic [PSC_WIDTH-1:0]      psc_q, psc_d;
   logic [WIDTH-1:0]          carrier_q, carrier_d;
   logic                      dir_q, dir_d;
   logic                      evt_zero_q, evt_zero_d;
   logic                      evt_top_q, evt_top_d;
   logic [1:0]                mode_act_q, mode_act_d;
   logic [WIDTH-1:0]          top_act_q, top_act_d;
   logic [CHANNELS*WIDTH-1:0] cmp_act_q, cmp_act_d;
   logic [CHANNELS-1:0]       pwm_q, pwm_d;

   logic                      tick;
   logic                      update;
   logic [1:0]                mode_new;

   // >= rather than == so a live shrink of psc_in cannot strand the count
   assign tick     = enable && (psc_q >= psc_in);
   assign psc_d    = (!enable || tick) ? '0 : psc_q + 1'b1;
   assign mode_new = (mode_in == 2'd3) ? MODE_UP : mode_in;

   always_comb begin
      carrier_d  = carrier_q;
      dir_d      = dir_q;
      mode_act_d = mode_act_q;
      top_act_d  = top_act_q;
      cmp_act_d  = cmp_act_q;
      evt_zero_d = 1'b0;
      evt_top_d  = 1'b0;
      update     = 1'b0;

      if (!enable) begin
         mode_act_d = mode_new;
         top_act_d  = top_in;
         cmp_act_d  = cmp_in;
      end else if (tick) begin
         case (mode_act_q)
            MODE_DN: begin
               if (carrier_q == '0) begin
                  update = 1'b1;
               end else begin
                  carrier_d = carrier_q - C_ONE;
                  dir_d     = 1'b0;
               end
            end
            MODE_TRI: begin
               if (dir_q) begin
                  if (top_act_q == '0) begin
                     update = 1'b1;
                  end else if (carrier_q >= top_act_q - C_ONE) begin
                     carrier_d = top_act_q;
                     dir_d     = 1'b0;
                  end else begin
                     carrier_d = carrier_q + C_ONE;
                  end
               end else begin
                  if (carrier_q <= C_ONE) begin
                     update = 1'b1;
                  end else begin
                     carrier_d = carrier_q - C_ONE;
                  end
               end
            end
            default: begin
               if (carrier_q >= top_act_q) begin
                  update = 1'b1;
               end else begin
                  carrier_d = carrier_q + C_ONE;
                  dir_d     = 1'b1;
               end
            end
         endcase

         // Carrier restarts in the shape of the newly loaded mode
         if (update) begin
            mode_act_d = mode_new;
            top_act_d  = top_in;
            cmp_act_d  = cmp_in;
            carrier_d  = (mode_new == MODE_DN) ? top_in : '0;
            dir_d      = (mode_new != MODE_DN);
         end

         evt_zero_d = (carrier_d == '0);
         evt_top_d  = (carrier_d == top_act_d);
      end
   end

   always_comb begin
      pwm_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_d[i] = (carrier_q < cmp_act_q[i*WIDTH +: WIDTH]);
      end
   end

   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb) begin
         psc_q      <= '0;
         carrier_q  <= '0;
         dir_q      <= 1'b1;
         evt_zero_q <= 1'b0;
         evt_top_q  <= 1'b0;
         mode_act_q <= MODE_UP;
         top_act_q  <= '1;
         cmp_act_q  <= '0;
         pwm_q      <= '0;
      end else begin
         psc_q      <= psc_d;
         carrier_q  <= carrier_d;
         dir_q      <= dir_d;
         evt_zero_q <= evt_zero_d;
         evt_top_q  <= evt_top_d;
         mode_act_q <= mode_act_d;
         top_act_q  <= top_act_d;
         cmp_act_q  <= cmp_act_d;
         pwm_q      <= pwm_d;
      end
   end

   assign carrier  = carrier_q;
   assign dir      = dir_q;
   assign evt_zero = evt_zero_q;
   assign evt_top  = evt_top_q;
   assign pwm_out  = pwm_q;

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Scoreboard bench for pwm_carrier_gen (WIDTH=8, CHANNELS=2, PSC_WIDTH=8).
module tb_pwm_carrier_gen;

   typedef struct packed {
      logic [7:0] c;
      logic       d;
      logic       ez;
      logic       et;
      logic [1:0] p;
   } exp_t;

   logic        cclk;
   logic        rstb;
   logic        enable;
   logic [1:0]  mode_in;
   logic [7:0]  top_in;
   logic [7:0]  psc_in;
   logic [15:0] cmp_in;
   logic [7:0]  carrier;
   logic        dir;
   logic        evt_zero;
   logic        evt_top;
   logic [1:0]  pwm_out;

   exp_t sb_q[$];
   int   n_vec;
   int   n_err;

   pwm_carrier_gen #(.WIDTH(8), .CHANNELS(2), .PSC_WIDTH(8)) dut (
      .cclk     (cclk),
      .rstb     (rstb),
      .enable   (enable),
      .mode_in  (mode_in),
      .top_in   (top_in),
      .psc_in   (psc_in),
      .cmp_in   (cmp_in),
      .carrier  (carrier),
      .dir      (dir),
      .evt_zero (evt_zero),
      .evt_top  (evt_top),
      .pwm_out  (pwm_out)
   );

   initial cclk = 1'b0;
   always #5 cclk = ~cclk;

   function automatic exp_t mk(int c, bit d, bit ez, bit et, bit p1, bit p0);
      exp_t e;
      e.c  = 8'(c);
      e.d  = d;
      e.ez = ez;
      e.et = et;
      e.p  = {p1, p0};
      return e;
   endfunction

   task automatic tick();
      @(posedge cclk);
      #1;
   endtask

   // Reset, then two idle clocks so the shadow inputs reach the active registers
   task automatic do_reset(input logic [1:0] m, input int top, input int psc,
                           input int c0, input int c1);
      rstb    = 1'b0;
      enable  = 1'b0;
      mode_in = m;
      top_in  = 8'(top);
      psc_in  = 8'(psc);
      cmp_in  = {8'(c1), 8'(c0)};
      #3;
      rstb = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      exp_t e, o;
      for (int s = 0; s < 9; s++) begin
         case (s)
            0: begin
               rstb = 1'b0; enable = 1'b0; mode_in = 2'd0; top_in = 8'd10;
               psc_in = 8'd0; cmp_in = {8'd8, 8'd3};
               repeat (2) @(posedge cclk);
               #1;
               sb_q.push_back(mk(0, 1, 0, 0, 0, 0));
            end
            1: begin
               rstb = 1'b1;
               tick();
               tick();
               sb_q.push_back(mk(0, 1, 0, 0, 1, 1));
            end
            2, 3, 4, 5, 6: begin
               if (s == 2) enable = 1'b1;
               tick();
               sb_q.push_back(mk(s - 1, 1, 0, 0, 1, (s - 2) < 3));
            end
            7: begin
               #2 rstb = 1'b0;
               #1;
               sb_q.push_back(mk(0, 1, 0, 0, 0, 0));
            end
            default: begin
               #2 rstb = 1'b1;
               tick();
               sb_q.push_back(mk(1, 1, 0, 0, 0, 0));
            end
         endcase
         e = sb_q.pop_front();
         o = {carrier, dir, evt_zero, evt_top, pwm_out};
         n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL reset step %0d: got c=%0d dir=%b ez=%b et=%b pwm=%b, want c=%0d dir=%b ez=%b et=%b pwm=%b",
                     s, o.c, o.d, o.ez, o.et, o.p, e.c, e.d, e.ez, e.et, e.p);
         end
      end
   endtask

   task automatic test_upsaw();
      exp_t e, o;
      int   prev, c, ticks;
      bit   en;
      do_reset(2'd0, 4, 0, 2, 5);
      enable = 1'b1;
      prev = 0;
      for (int n = 1; n <= 17; n++) begin
         en    = !(n >= 13 && n <= 15);
         ticks = (n <= 12) ? n : ((n <= 15) ? 12 : n - 3);
         c     = ticks % 5;
         sb_q.push_back(mk(c, 1, en && c == 0, en && c == 4, 1, prev < 2));
         prev = c;
      end
      for (int n = 1; n <= 17; n++) begin
         if (n == 13) enable = 1'b0;
         if (n == 16) enable = 1'b1;
         tick();
         e = sb_q.pop_front();
         o = {carrier, dir, evt_zero, evt_top, pwm_out};
         n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL upsaw n=%0d: got c=%0d dir=%b ez=%b et=%b pwm=%b, want c=%0d dir=%b ez=%b et=%b pwm=%b",
                     n, o.c, o.d, o.ez, o.et, o.p, e.c, e.d, e.ez, e.et, e.p);
         end
      end
   endtask

   task automatic test_triangle();
      exp_t e, o;
      int   tri_tab[6] = '{0, 1, 2, 3, 2, 1};
      int   prev, c, ph;
      do_reset(2'd2, 3, 0, 2, 0);
      enable = 1'b1;
      prev = 0;
      for (int n = 1; n <= 13; n++) begin
         ph = n % 6;
         c  = tri_tab[ph];
         sb_q.push_back(mk(c, !(ph >= 3), c == 0, c == 3, 0, prev < 2));
         prev = c;
      end
      for (int n = 1; n <= 13; n++) begin
         tick();
         e = sb_q.pop_front();
         o = {carrier, dir, evt_zero, evt_top, pwm_out};
         n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL triangle n=%0d: got c=%0d dir=%b ez=%b et=%b pwm=%b, want c=%0d dir=%b ez=%b et=%b pwm=%b",
                     n, o.c, o.d, o.ez, o.et, o.p, e.c, e.d, e.ez, e.et, e.p);
         end
      end
   endtask

   task automatic test_prescaler();
      exp_t e, o;
      int   prev, c;
      bit   on_tick;
      do_reset(2'd0, 2, 2, 1, 3);
      enable = 1'b1;
      prev = 0;
      for (int n = 1; n <= 12; n++) begin
         c       = (n / 3) % 3;
         on_tick = (n % 3 == 0);
         sb_q.push_back(mk(c, 1, on_tick && c == 0, on_tick && c == 2, 1, prev < 1));
         prev = c;
      end
      for (int n = 1; n <= 12; n++) begin
         tick();
         e = sb_q.pop_front();
         o = {carrier, dir, evt_zero, evt_top, pwm_out};
         n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL prescaler n=%0d: got c=%0d dir=%b ez=%b et=%b pwm=%b, want c=%0d dir=%b ez=%b et=%b pwm=%b",
                     n, o.c, o.d, o.ez, o.et, o.p, e.c, e.d, e.ez, e.et, e.p);
         end
      end
   endtask

   task automatic test_shadow();
      exp_t e, o;
      int   prev, c, topv, cmpv;
      do_reset(2'd0, 4, 0, 1, 7);
      enable = 1'b1;
      prev = 0;
      for (int n = 1; n <= 19; n++) begin
         c    = (n <= 5) ? n % 5 : (n - 5) % 7;
         topv = (n < 5) ? 4 : 6;
         cmpv = (n - 1 >= 5) ? 3 : 1;
         sb_q.push_back(mk(c, 1, c == 0, c == topv, 1, prev < cmpv));
         prev = c;
      end
      for (int n = 1; n <= 19; n++) begin
         if (n == 3) begin
            top_in = 8'd6;
            cmp_in = {8'd7, 8'd3};
         end
         tick();
         e = sb_q.pop_front();
         o = {carrier, dir, evt_zero, evt_top, pwm_out};
         n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL shadow n=%0d: got c=%0d dir=%b ez=%b et=%b pwm=%b, want c=%0d dir=%b ez=%b et=%b pwm=%b",
                     n, o.c, o.d, o.ez, o.et, o.p, e.c, e.d, e.ez, e.et, e.p);
         end
      end
   endtask

   task automatic test_mode_top0();
      exp_t e, o;
      int   c_tab[17] = '{1, 2, 3, 4, 3, 2, 1, 0, 3, 2, 1, 0, 0, 0, 0, 0, 0};
      int   prev, c, topv;
      bit   d;
      do_reset(2'd0, 4, 0, 2, 0);
      enable = 1'b1;
      prev = 0;
      for (int n = 1; n <= 17; n++) begin
         c    = c_tab[n-1];
         topv = (n < 5) ? 4 : ((n <= 12) ? 3 : 0);
         d    = (n <= 4) || (n >= 16);
         sb_q.push_back(mk(c, d, c == 0, c == topv, 0, prev < 2));
         prev = c;
      end
      for (int n = 1; n <= 17; n++) begin
         if (n == 3) begin
            mode_in = 2'd1;
            top_in  = 8'd3;
         end
         if (n == 10) top_in = 8'd0;
         if (n == 16) mode_in = 2'd0;
         tick();
         e = sb_q.pop_front();
         o = {carrier, dir, evt_zero, evt_top, pwm_out};
         n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL mode_top0 n=%0d: got c=%0d dir=%b ez=%b et=%b pwm=%b, want c=%0d dir=%b ez=%b et=%b pwm=%b",
                     n, o.c, o.d, o.ez, o.et, o.p, e.c, e.d, e.ez, e.et, e.p);
         end
      end
   endtask

   task automatic test_full_range();
      exp_t e, o;
      int   prev, c;
      do_reset(2'd0, 255, 0, 255, 0);
      enable = 1'b1;
      prev = 0;
      for (int n = 1; n <= 258; n++) begin
         c = n % 256;
         sb_q.push_back(mk(c, 1, c == 0, c == 255, 0, prev < 255));
         prev = c;
      end
      for (int n = 1; n <= 258; n++) begin
         tick();
         e = sb_q.pop_front();
         o = {carrier, dir, evt_zero, evt_top, pwm_out};
         n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL full_range n=%0d: got c=%0d dir=%b ez=%b et=%b pwm=%b, want c=%0d dir=%b ez=%b et=%b pwm=%b",
                     n, o.c, o.d, o.ez, o.et, o.p, e.c, e.d, e.ez, e.et, e.p);
         end
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rstb    = 1'b0;
      enable  = 1'b0;
      mode_in = 2'd0;
      top_in  = 8'd0;
      psc_in  = 8'd0;
      cmp_in  = 16'd0;
      test_reset();
      test_upsaw();
      test_triangle();
      test_prescaler();
      test_shadow();
      test_mode_top0();
      test_full_range();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d vectors, want completion", n_vec);
      $fatal(1);
   end

endmodule
